// File: rtl/mod6343_pkg.sv
// Shared widths, modulus constants and FSM states for the mod-6343 poly-multiply datapath.
package mod6343_pkg;
    localparam int Q     = 6343;
    localparam int QH    = 3171;
    localparam int AW    = 13;
    localparam int PW    = 25;
    localparam int OW    = 35;
    localparam int NTERM = 1024;
    localparam int CW    = $clog2(NTERM);

    typedef enum logic [1:0] {
        S_ACC   = 2'd0,
        S_DRAIN = 2'd1,
        S_OUT   = 2'd2
    } state_t;

    function automatic logic signed [OW-1:0] sext_p(input logic signed [PW-1:0] p);
        return {{(OW-PW){p[PW-1]}}, p};
    endfunction
endpackage

// File: rtl/mul13s_reg.sv
// Registered signed AW x AW multiplier; product truncated to PW bits, valid follows en by one edge.
module mul13s_reg
    import mod6343_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic signed [AW-1:0] a,
    input  logic signed [AW-1:0] b,
    output logic signed [PW-1:0] p,
    output logic                 p_valid
);
    logic signed [2*AW-1:0] full_prod;
    logic signed [PW-1:0]   p_d, p_q;
    logic                   p_valid_d, p_valid_q;

    always_comb begin
        full_prod = a * b;
        p_d       = p_q;
        p_valid_d = en;
        if (en) begin
            p_d = full_prod[PW-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q       <= '0;
            p_valid_q <= 1'b0;
        end else begin
            p_q       <= p_d;
            p_valid_q <= p_valid_d;
        end
    end

    assign p       = p_q;
    assign p_valid = p_valid_q;
endmodule

// File: rtl/mac_acc_6343_s35.sv
// Signed multiply-accumulate: sums up to NTERM products per group and emits one OW-bit sum per group.
module mac_acc_6343_s35
    import mod6343_pkg::*;
(
    input  logic                 clk,
    input  logic                 Reset,
    input  logic                 In_valid,
    output logic                 In_ready,
    input  logic                 In_last,
    input  logic signed [AW-1:0] InA,
    input  logic signed [AW-1:0] InB,
    output logic                 Out_valid,
    input  logic                 Out_ready,
    output logic signed [OW-1:0] Out,
    output logic                 Out_err
);
    state_t               state_d, state_q;
    logic signed [OW-1:0] acc_d, acc_q;
    logic [CW-1:0]        count_d, count_q;
    logic                 err_d, err_q;
    logic signed [OW-1:0] out_d, out_q;
    logic                 out_valid_d, out_valid_q;
    logic                 out_err_d, out_err_q;

    logic                 accept;
    logic signed [PW-1:0] p;
    logic                 p_valid;
    logic signed [OW-1:0] p_ext;

    assign In_ready = (state_q == S_ACC);
    assign accept   = In_valid && In_ready;

    mul13s_reg u_mul (
        .clk     (clk),
        .rst_n   (Reset),
        .en      (accept),
        .a       (InA),
        .b       (InB),
        .p       (p),
        .p_valid (p_valid)
    );

    // Product register only holds a fresh term for one cycle, so gate the add with its valid.
    assign p_ext = p_valid ? sext_p(p) : '0;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        count_d     = count_q;
        err_d       = err_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        out_err_d   = out_err_q;
        case (state_q)
            S_ACC: begin
                acc_d = acc_q + p_ext;
                if (accept) begin
                    count_d = count_q + 1'b1;
                    if (In_last || (count_q == CW'(NTERM - 1))) begin
                        state_d = S_DRAIN;
                        if (!In_last) begin
                            err_d = 1'b1;
                        end
                    end
                end
            end
            S_DRAIN: begin
                // Terminal product is still in the multiplier register; fold it in here.
                out_d       = acc_q + p_ext;
                out_err_d   = err_q;
                out_valid_d = 1'b1;
                acc_d       = '0;
                count_d     = '0;
                err_d       = 1'b0;
                state_d     = S_OUT;
            end
            S_OUT: begin
                if (out_valid_q && Out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_ACC;
                end
            end
            default: begin
                state_d = S_ACC;
            end
        endcase
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_q     <= S_ACC;
            acc_q       <= '0;
            count_q     <= '0;
            err_q       <= 1'b0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            err_q       <= err_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            out_err_q   <= out_err_d;
        end
    end

    assign Out       = out_q;
    assign Out_valid = out_valid_q;
    assign Out_err   = out_err_q;
endmodule
